// File: rtl/control.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute for the datapath
// and handshakes with the memory port. Moore outputs, forced to defaults in reset.
`timescale 1ns/1ps
module control (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       br_en,
  input  logic [1:0] mem_addr_lo,
  input  logic       mem_resp,
  output logic       mem_read,
  output logic       mem_write,
  output logic [3:0] mem_byte_enable,
  output logic       load_pc,
  output logic       load_ir,
  output logic       load_regfile,
  output logic       load_mar,
  output logic       load_mdr,
  output logic       load_data_out,
  output logic [1:0] pcmux_sel,
  output logic       alumux1_sel,
  output logic [2:0] alumux2_sel,
  output logic [3:0] regfilemux_sel,
  output logic       marmux_sel,
  output logic       cmpmux_sel,
  output logic [2:0] aluop,
  output logic [2:0] cmpop
);

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;

  localparam logic [2:0] ALU_SRA  = 3'd2;
  localparam logic [2:0] ALU_SUB  = 3'd3;
  localparam logic [2:0] CMP_BLT  = 3'd4;
  localparam logic [2:0] CMP_BLTU = 3'd6;

  localparam logic [3:0] RF_ALU = 4'd0, RF_BR = 4'd1, RF_UIMM = 4'd2, RF_LW = 4'd3,
                         RF_PC4 = 4'd4, RF_LB = 4'd5, RF_LBU = 4'd6, RF_LH = 4'd7,
                         RF_LHU = 4'd8;

  typedef enum logic [4:0] {
    S_FETCH1, S_FETCH2, S_FETCH3, S_DECODE,
    S_LUI, S_AUIPC, S_IMM, S_REG, S_BR, S_JAL, S_JALR,
    S_CALC_ADDR, S_LD1, S_LD2, S_ST1, S_ST2, S_ILLEGAL
  } state_t;

  state_t r_state, w_next;
  logic   w_unused_funct7;

  assign w_unused_funct7 = ^{funct7[6], funct7[4:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_FETCH1;
    else      r_state <= w_next;
  end

  always_comb begin
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_byte_enable = '0;
    load_pc         = 1'b0;
    load_ir         = 1'b0;
    load_regfile    = 1'b0;
    load_mar        = 1'b0;
    load_mdr        = 1'b0;
    load_data_out   = 1'b0;
    pcmux_sel       = 2'd0;
    alumux1_sel     = 1'b0;
    alumux2_sel     = 3'd0;
    regfilemux_sel  = RF_ALU;
    marmux_sel      = 1'b0;
    cmpmux_sel      = 1'b0;
    aluop           = 3'd0;
    cmpop           = 3'd0;
    w_next          = r_state;
    // Output decode is gated by rst so reset holds every strobe and enable low.
    if (rst) begin
      unique case (r_state)
        S_FETCH1: begin
          load_mar = 1'b1;
          w_next   = S_FETCH2;
        end
        S_FETCH2: begin
          mem_read = 1'b1;
          load_mdr = 1'b1;
          if (mem_resp) w_next = S_FETCH3;
        end
        S_FETCH3: begin
          load_ir = 1'b1;
          w_next  = S_DECODE;
        end
        S_DECODE: begin
          case (opcode)
            OP_LUI:             w_next = S_LUI;
            OP_AUIPC:           w_next = S_AUIPC;
            OP_IMM:             w_next = S_IMM;
            OP_REG:             w_next = S_REG;
            OP_BR:              w_next = S_BR;
            OP_JAL:             w_next = S_JAL;
            OP_JALR:            w_next = S_JALR;
            OP_LOAD, OP_STORE:  w_next = S_CALC_ADDR;
            default:            w_next = S_ILLEGAL;
          endcase
        end
        S_LUI: begin
          load_regfile   = 1'b1;
          regfilemux_sel = RF_UIMM;
          load_pc        = 1'b1;
          w_next         = S_FETCH1;
        end
        S_AUIPC: begin
          alumux1_sel  = 1'b1;
          alumux2_sel  = 3'd1;
          load_regfile = 1'b1;
          load_pc      = 1'b1;
          w_next       = S_FETCH1;
        end
        S_IMM, S_REG: begin
          load_regfile = 1'b1;
          load_pc      = 1'b1;
          w_next       = S_FETCH1;
          if (r_state == S_REG) alumux2_sel = 3'd5;
          if (funct3 == 3'b010 || funct3 == 3'b011) begin
            cmpmux_sel     = (r_state == S_IMM);
            cmpop          = funct3[0] ? CMP_BLTU : CMP_BLT;
            regfilemux_sel = RF_BR;
          end else if (funct3 == 3'b101 && funct7[5]) begin
            aluop = ALU_SRA;
          end else if (funct3 == 3'b000 && funct7[5] && r_state == S_REG) begin
            aluop = ALU_SUB;
          end else begin
            aluop = funct3;
          end
        end
        S_BR: begin
          cmpop       = funct3;
          alumux1_sel = 1'b1;
          alumux2_sel = 3'd2;
          pcmux_sel   = br_en ? 2'd1 : 2'd0;
          load_pc     = 1'b1;
          w_next      = S_FETCH1;
        end
        S_JAL: begin
          regfilemux_sel = RF_PC4;
          load_regfile   = 1'b1;
          alumux1_sel    = 1'b1;
          alumux2_sel    = 3'd4;
          pcmux_sel      = 2'd1;
          load_pc        = 1'b1;
          w_next         = S_FETCH1;
        end
        S_JALR: begin
          regfilemux_sel = RF_PC4;
          load_regfile   = 1'b1;
          pcmux_sel      = 2'd2;
          load_pc        = 1'b1;
          w_next         = S_FETCH1;
        end
        S_CALC_ADDR: begin
          alumux2_sel = (opcode == OP_STORE) ? 3'd3 : 3'd0;
          marmux_sel  = 1'b1;
          load_mar    = 1'b1;
          if (opcode == OP_STORE) begin
            load_data_out = 1'b1;
            w_next        = S_ST1;
          end else begin
            w_next        = S_LD1;
          end
        end
        S_LD1: begin
          mem_read = 1'b1;
          load_mdr = 1'b1;
          if (mem_resp) w_next = S_LD2;
        end
        S_LD2: begin
          load_regfile = 1'b1;
          load_pc      = 1'b1;
          w_next       = S_FETCH1;
          case (funct3)
            3'b000:  regfilemux_sel = RF_LB;
            3'b001:  regfilemux_sel = RF_LH;
            3'b100:  regfilemux_sel = RF_LBU;
            3'b101:  regfilemux_sel = RF_LHU;
            default: regfilemux_sel = RF_LW;
          endcase
        end
        S_ST1: begin
          mem_write = 1'b1;
          case (funct3)
            3'b000:  mem_byte_enable = 4'b0001 << mem_addr_lo;
            3'b001:  mem_byte_enable = 4'b0011 << mem_addr_lo;
            3'b010:  mem_byte_enable = 4'b1111;
            default: mem_byte_enable = 4'b0000;
          endcase
          if (mem_resp) w_next = S_ST2;
        end
        S_ST2: begin
          load_pc = 1'b1;
          w_next  = S_FETCH1;
        end
        S_ILLEGAL: begin
          load_pc = 1'b1;
          w_next  = S_FETCH1;
        end
        default: w_next = S_FETCH1;
      endcase
    end
  end

endmodule

// File: tb/tb_control.sv
// Bench for control: directed scenarios plus randomized instructions checked
// cycle-by-cycle against an instruction-level model of the expected outputs.
`timescale 1ns/1ps
module tb_control;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic [6:0] funct7 = '0;
  logic       br_en = 1'b0;
  logic [1:0] mem_addr_lo = '0;
  logic       mem_resp = 1'b0;
  logic       mem_read, mem_write;
  logic [3:0] mem_byte_enable;
  logic       load_pc, load_ir, load_regfile, load_mar, load_mdr, load_data_out;
  logic [1:0] pcmux_sel;
  logic       alumux1_sel;
  logic [2:0] alumux2_sel;
  logic [3:0] regfilemux_sel;
  logic       marmux_sel, cmpmux_sel;
  logic [2:0] aluop, cmpop;

  always #5 clk = ~clk;

  control dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .br_en(br_en), .mem_addr_lo(mem_addr_lo), .mem_resp(mem_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_byte_enable(mem_byte_enable),
    .load_pc(load_pc), .load_ir(load_ir), .load_regfile(load_regfile),
    .load_mar(load_mar), .load_mdr(load_mdr), .load_data_out(load_data_out),
    .pcmux_sel(pcmux_sel), .alumux1_sel(alumux1_sel), .alumux2_sel(alumux2_sel),
    .regfilemux_sel(regfilemux_sel), .marmux_sel(marmux_sel), .cmpmux_sel(cmpmux_sel),
    .aluop(aluop), .cmpop(cmpop)
  );

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic [3:0] mbe;
    logic       load_pc;
    logic       load_ir;
    logic       load_regfile;
    logic       load_mar;
    logic       load_mdr;
    logic       load_data_out;
    logic [1:0] pcmux;
    logic       alumux1;
    logic [2:0] alumux2;
    logic [3:0] regfilemux;
    logic       marmux;
    logic       cmpmux;
    logic [2:0] aluop;
    logic [2:0] cmpop;
  } outs_t;

  localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_BR = 7'b1100011, OP_LOAD = 7'b0000011,
                         OP_STORE = 7'b0100011, OP_IMM = 7'b0010011, OP_REG = 7'b0110011,
                         OP_SYS = 7'b1110011;
  localparam logic [6:0] F7_ALT = 7'b0100000;

  int    n_chk  = 0;
  int    n_pass = 0;
  int    n_fail = 0;
  outs_t trace[$];

  function automatic outs_t dut_outs();
    outs_t o;
    o.mem_read = mem_read;         o.mem_write = mem_write;
    o.mbe = mem_byte_enable;       o.load_pc = load_pc;
    o.load_ir = load_ir;           o.load_regfile = load_regfile;
    o.load_mar = load_mar;         o.load_mdr = load_mdr;
    o.load_data_out = load_data_out; o.pcmux = pcmux_sel;
    o.alumux1 = alumux1_sel;       o.alumux2 = alumux2_sel;
    o.regfilemux = regfilemux_sel; o.marmux = marmux_sel;
    o.cmpmux = cmpmux_sel;         o.aluop = aluop;
    o.cmpop = cmpop;
    return o;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_legal(input logic [6:0] op);
    return op inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BR, OP_LOAD, OP_STORE, OP_IMM, OP_REG};
  endfunction

  // Expected outputs of the single execute cycle of a non-memory instruction.
  function automatic outs_t exec_model(input logic [6:0] op, input logic [2:0] f3,
                                       input logic [6:0] f7, input logic br);
    outs_t e = '0;
    bit    is_reg = (op == OP_REG);
    e.load_pc = 1'b1;
    case (op)
      OP_LUI:   begin e.load_regfile = 1'b1; e.regfilemux = 4'd2; end
      OP_AUIPC: begin e.load_regfile = 1'b1; e.alumux1 = 1'b1; e.alumux2 = 3'd1; end
      OP_IMM, OP_REG: begin
        e.load_regfile = 1'b1;
        if (is_reg) e.alumux2 = 3'd5;
        if (f3 == 3'd2 || f3 == 3'd3) begin
          e.regfilemux = 4'd1;
          e.cmpmux     = !is_reg;
          e.cmpop      = (f3 == 3'd2) ? 3'd4 : 3'd6;
        end else if (f3 == 3'd5) begin
          e.aluop = f7[5] ? 3'd2 : 3'd5;
        end else if (f3 == 3'd0) begin
          e.aluop = (is_reg && f7[5]) ? 3'd3 : 3'd0;
        end else begin
          e.aluop = f3;
        end
      end
      OP_BR: begin
        e.cmpop = f3; e.alumux1 = 1'b1; e.alumux2 = 3'd2; e.pcmux = br ? 2'd1 : 2'd0;
      end
      OP_JAL: begin
        e.load_regfile = 1'b1; e.regfilemux = 4'd4; e.alumux1 = 1'b1; e.alumux2 = 3'd4;
        e.pcmux = 2'd1;
      end
      OP_JALR: begin e.load_regfile = 1'b1; e.regfilemux = 4'd4; e.pcmux = 2'd2; end
      default: ;
    endcase
    return e;
  endfunction

  function automatic logic [3:0] store_mask(input logic [2:0] f3, input logic [1:0] lo);
    int m;
    case (f3)
      3'd0:    m = 1 << lo;
      3'd1:    m = 3 << lo;
      3'd2:    m = 15;
      default: m = 0;
    endcase
    return 4'(m & 15);
  endfunction

  // Builds the full expected cycle sequence for one instruction, then steps the DUT
  // through it; mem_resp is random outside memory wait states (must be ignored).
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                           input logic br, input logic [1:0] lo, input int w1, input int w2,
                           input string tag);
    outs_t exp_q[$];
    bit    resp_q[$];
    bit    memc_q[$];
    outs_t e;
    int    ld_sel[8] = '{5, 7, 3, 3, 6, 8, 3, 3};
    opcode = op; funct3 = f3; funct7 = f7; br_en = br; mem_addr_lo = lo;
    e = '0; e.load_mar = 1'b1;
    exp_q.push_back(e); resp_q.push_back(1'b0); memc_q.push_back(1'b0);
    for (int i = 0; i <= w1; i++) begin
      e = '0; e.mem_read = 1'b1; e.load_mdr = 1'b1;
      exp_q.push_back(e); resp_q.push_back(i == w1); memc_q.push_back(1'b1);
    end
    e = '0; e.load_ir = 1'b1;
    exp_q.push_back(e); resp_q.push_back(1'b0); memc_q.push_back(1'b0);
    e = '0;
    exp_q.push_back(e); resp_q.push_back(1'b0); memc_q.push_back(1'b0);
    if (op == OP_LOAD || op == OP_STORE) begin
      e = '0; e.marmux = 1'b1; e.load_mar = 1'b1;
      e.alumux2 = (op == OP_STORE) ? 3'd3 : 3'd0;
      e.load_data_out = (op == OP_STORE);
      exp_q.push_back(e); resp_q.push_back(1'b0); memc_q.push_back(1'b0);
      for (int i = 0; i <= w2; i++) begin
        e = '0;
        if (op == OP_LOAD) begin e.mem_read = 1'b1; e.load_mdr = 1'b1; end
        else begin e.mem_write = 1'b1; e.mbe = store_mask(f3, lo); end
        exp_q.push_back(e); resp_q.push_back(i == w2); memc_q.push_back(1'b1);
      end
      e = '0; e.load_pc = 1'b1;
      if (op == OP_LOAD) begin e.load_regfile = 1'b1; e.regfilemux = 4'(ld_sel[f3]); end
      exp_q.push_back(e); resp_q.push_back(1'b0); memc_q.push_back(1'b0);
    end else begin
      exp_q.push_back(exec_model(op, f3, f7, br));
      resp_q.push_back(1'b0); memc_q.push_back(1'b0);
    end
    trace.delete();
    foreach (exp_q[k]) begin
      @(negedge clk);
      trace.push_back(dut_outs());
      chk($sformatf("%s.cyc%0d", tag, k), 32'(dut_outs()), 32'(exp_q[k]));
      mem_resp = memc_q[k] ? resp_q[k] : 1'($urandom_range(0, 1));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int    cnt;
    outs_t e;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [2:0] br_f3[6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};

    // Reset and fetch
    rst = 1'b0;
    opcode = OP_REG;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("reset_outs%0d", i), 32'(dut_outs()), 32'd0);
    end
    @(posedge clk); #1 rst = 1'b1;
    run_instr(OP_REG, 3'd0, 7'd0, 1'b0, 2'd0, 2, 0, "add_w2");
    chk("fetch1_load_mar", 32'(trace[0].load_mar), 32'd1);
    cnt = 0; foreach (trace[k]) cnt += int'(trace[k].mem_read);
    chk("fetch_mem_read_cycles", 32'(cnt), 32'd3);
    cnt = 0; foreach (trace[k]) cnt += int'(trace[k].load_ir);
    chk("load_ir_pulses", 32'(cnt), 32'd1);

    // add then sub
    run_instr(OP_REG, 3'd0, 7'd0, 1'b0, 2'd0, 0, 0, "add");
    chk("add_latency", 32'(trace.size()), 32'd5);
    chk("add_aluop", 32'(trace[4].aluop), 32'd0);
    chk("add_alumux2", 32'(trace[4].alumux2), 32'd5);
    chk("add_load_regfile", 32'(trace[4].load_regfile), 32'd1);
    chk("add_load_pc", 32'(trace[4].load_pc), 32'd1);
    chk("add_pcmux", 32'(trace[4].pcmux), 32'd0);
    run_instr(OP_REG, 3'd0, F7_ALT, 1'b0, 2'd0, 0, 0, "sub");
    chk("sub_aluop", 32'(trace[4].aluop), 32'd3);

    // Branch taken / not taken
    run_instr(OP_BR, 3'd0, 7'd0, 1'b1, 2'd0, 0, 0, "beq_t");
    chk("beq_taken_pcmux", 32'(trace[4].pcmux), 32'd1);
    chk("beq_taken_cmpop", 32'(trace[4].cmpop), 32'd0);
    chk("beq_taken_alumux2", 32'(trace[4].alumux2), 32'd2);
    run_instr(OP_BR, 3'd0, 7'd0, 1'b0, 2'd0, 0, 0, "beq_nt");
    chk("beq_nt_pcmux", 32'(trace[4].pcmux), 32'd0);
    chk("beq_nt_alumux2", 32'(trace[4].alumux2), 32'd2);

    // lbu with one memory wait
    run_instr(OP_LOAD, 3'd4, 7'd0, 1'b0, 2'd1, 0, 1, "lbu");
    chk("lbu_latency", 32'(trace.size()), 32'd8);
    chk("lbu_calc_marmux", 32'(trace[4].marmux), 32'd1);
    chk("lbu_calc_load_mar", 32'(trace[4].load_mar), 32'd1);
    chk("lbu_ld1_hold", 32'({trace[5].mem_read, trace[6].mem_read}), 32'd3);
    chk("lbu_regfilemux", 32'(trace[7].regfilemux), 32'd6);
    chk("lbu_load_regfile", 32'(trace[7].load_regfile), 32'd1);
    run_instr(OP_LOAD, 3'd2, 7'd0, 1'b0, 2'd0, 0, 0, "lw");
    chk("lw_latency", 32'(trace.size()), 32'd7);

    // Stores
    run_instr(OP_STORE, 3'd0, 7'd0, 1'b0, 2'd3, 0, 2, "sb");
    chk("sb_mbe", 32'(trace[5].mbe), 32'b1000);
    chk("sb_load_data_out", 32'(trace[4].load_data_out), 32'd1);
    chk("sb_mem_write_held", 32'({trace[5].mem_write, trace[6].mem_write, trace[7].mem_write}), 32'd7);
    run_instr(OP_STORE, 3'd1, 7'd0, 1'b0, 2'd2, 0, 0, "sh");
    chk("sh_mbe", 32'(trace[5].mbe), 32'b1100);

    // JALR and illegal opcode
    run_instr(OP_JALR, 3'd0, 7'd0, 1'b0, 2'd0, 0, 0, "jalr");
    chk("jalr_pcmux", 32'(trace[4].pcmux), 32'd2);
    chk("jalr_regfilemux", 32'(trace[4].regfilemux), 32'd4);
    run_instr(OP_SYS, 3'd0, 7'd0, 1'b0, 2'd0, 0, 0, "ecall");
    e = '0; e.load_pc = 1'b1;
    chk("illegal_outs", 32'(trace[4]), 32'(e));

    // Reset during an LD1 wait
    mem_resp = 1'b0;
    opcode = OP_LOAD; funct3 = 3'd2;
    @(negedge clk); mem_resp = 1'b0;             // FETCH1
    @(negedge clk); mem_resp = 1'b1;             // FETCH2
    @(negedge clk); mem_resp = 1'b0;             // FETCH3
    @(negedge clk);                              // DECODE
    @(negedge clk);                              // CALC_ADDR
    @(negedge clk);                              // LD1
    chk("ld1_mem_read", 32'(mem_read), 32'd1);
    @(negedge clk);                              // LD1 still waiting
    chk("ld1_wait_mem_read", 32'(mem_read), 32'd1);
    rst = 1'b0;
    #1;
    chk("abort_mem_read", 32'(mem_read), 32'd0);
    chk("abort_outs", 32'(dut_outs()), 32'd0);
    @(negedge clk);
    chk("abort_hold_outs", 32'(dut_outs()), 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    run_instr(OP_IMM, 3'd0, 7'd0, 1'b0, 2'd0, 0, 0, "post_reset_addi");

    // Randomized instruction stream
    for (int n = 0; n < 80; n++) begin
      f3 = 3'($urandom_range(0, 7));
      f7 = ($urandom_range(0, 1) == 1) ? F7_ALT : 7'd0;
      if ($urandom_range(0, 3) == 0) f7 = 7'($urandom);
      case ($urandom_range(0, 10))
        0: op = OP_LUI;
        1: op = OP_AUIPC;
        2: op = OP_IMM;
        3: op = OP_REG;
        4: begin op = OP_BR; f3 = br_f3[$urandom_range(0, 5)]; end
        5: op = OP_JAL;
        6: op = OP_JALR;
        7: op = OP_LOAD;
        8: begin op = OP_STORE; f3 = 3'($urandom_range(0, 2)); end
        9: op = OP_SYS;
        default: begin
          op = 7'($urandom);
          if (is_legal(op)) op = OP_SYS;
        end
      endcase
      run_instr(op, f3, f7, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                $urandom_range(0, 3), $urandom_range(0, 3), $sformatf("rnd%0d", n));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/control.md
# control

Multicycle RV32I control unit that sequences the `datapath` block. It is a Moore state machine: it walks each instruction through fetch, decode and execute. It drives every datapath load enable, mux select and ALU/CMP op, and performs the `mem_read`/`mem_write`/`mem_resp` handshake with the memory port. There is one instruction in flight at a time, and there are no parameters.

## Interface
- No parameters.
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-low reset.
- `opcode` in 7: IR opcode.
- `funct3` in 3: IR funct3.
- `funct7` in 7: IR funct7.
- `br_en` in 1: CMP result.
- `mem_addr_lo` in 2: MAR bits [1:0], used for store byte enables.
- `mem_resp` in 1: memory completion, one-cycle pulse.
- `mem_read`, `mem_write` out 1: memory strobes.
- `mem_byte_enable` out 4: store lane mask.
- `load_pc`, `load_ir`, `load_regfile`, `load_mar`, `load_mdr`, `load_data_out` out 1: register enables.
- `pcmux_sel` out 2: 0 pc_plus4, 1 alu_out, 2 alu_mod2.
- `alumux1_sel` out 1: 0 rs1_out, 1 pc_out.
- `alumux2_sel` out 3: 0 i_imm, 1 u_imm, 2 b_imm, 3 s_imm, 4 j_imm, 5 rs2_out.
- `regfilemux_sel` out 4: 0 alu_out, 1 br_en, 2 u_imm, 3 lw, 4 pc_plus4, 5 lb, 6 lbu, 7 lh, 8 lhu.
- `marmux_sel` out 1: 0 pc_out, 1 alu_out.
- `cmpmux_sel` out 1: 0 rs2_out, 1 i_imm.
- `aluop` out 3: add 0, sll 1, sra 2, sub 3, xor 4, srl 5, or 6, and 7.
- `cmpop` out 3: beq 0, bne 1, blt 4, bge 5, bltu 6, bgeu 7.

## Operation
**Defaults.** Every state starts from all outputs 0, `aluop`=add, `cmpop`=beq, and then sets only what it lists below.

**Fetch and decode states.**
- FETCH1: `load_mar`, marmux=pc_out.
- FETCH2: `mem_read`, `load_mdr`. Holds until `mem_resp`.
- FETCH3: `load_ir`.
- DECODE: no outputs asserted. The next state is selected by `opcode`.

**Execute states.** Every execute state except CALC_ADDR/LD1/ST1 asserts `load_pc` and returns to FETCH1.
- LUI (0110111): `load_regfile`, regfilemux=u_imm, `load_pc`.
- AUIPC (0010111): alumux1=pc, alumux2=u_imm, add, regfilemux=alu_out, `load_regfile`, `load_pc`.
- IMM (0010011):
  - slti/sltiu: cmpmux=i_imm, cmpop=blt/bltu, regfilemux=br_en.
  - srai (funct3 101, funct7[5]=1): aluop=sra.
  - All others: aluop=funct3, alumux2=i_imm.
  - Always `load_regfile` and `load_pc`.
- REG (0110011):
  - Same as IMM, but alumux2=rs2_out and cmpmux=rs2_out.
  - funct3 000 with funct7[5]=1 gives sub.
  - funct3 101 with funct7[5]=1 gives sra.
- BR (1100011): cmpop=funct3, alumux1=pc, alumux2=b_imm, add, `load_pc`. pcmux is alu_out if `br_en`, else pc_plus4.
- JAL (1101111): regfilemux=pc_plus4, `load_regfile`, alumux1=pc, alumux2=j_imm, pcmux=alu_out, `load_pc`.
- JALR (1100111): as JAL, but alumux1=rs1, alumux2=i_imm, pcmux=alu_mod2.

**Load/store states.**
- CALC_ADDR:
  - Entered for load (0000011) or store (0100011).
  - Outputs: alumux2 = i_imm (load) or s_imm (store), add, marmux=alu_out, `load_mar`. A store also asserts `load_data_out`.
  - Next state: LD1 or ST1.
- LD1: `mem_read`, `load_mdr`. Holds until `mem_resp`, then goes to LD2.
- LD2: `load_regfile`, `load_pc`. regfilemux by funct3: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu. Any other funct3 selects lw.
- ST1: `mem_write`. Holds until `mem_resp`, then goes to ST2.
  - `mem_byte_enable` by funct3, truncated to 4 bits: sw = 1111, sh = 0011<<`mem_addr_lo`, sb = 0001<<`mem_addr_lo`.
  - Misalignment is not trapped.
- ST2: `load_pc`.

**Illegal opcodes.** Any other opcode, including 1110011, goes from DECODE to ILLEGAL. ILLEGAL asserts only `load_pc` (pc_plus4) and returns to FETCH1.

## Timing
**Reset.**
- `rst` low asynchronously sets state to FETCH1.
- While `rst` is low, all outputs are forced to their defaults, so `load_mar`=0.
- FETCH1 outputs appear in the first cycle after `rst` is released.

**Memory handshake.**
- `mem_read` and `mem_write` stay high, with address and enables stable, every cycle until the cycle in which `mem_resp`=1.
- The transition happens on the edge that ends that cycle.
- `mem_resp` outside FETCH2/LD1/ST1 is ignored.

**Latency** (with 1-cycle `mem_resp`):
- ALU, branch and jump instructions: 5 cycles (FETCH1, FETCH2, FETCH3, DECODE, EXEC).
- Loads and stores: 7 cycles.
- Each extra memory wait cycle adds 1.

**Other rules.**
- All outputs are decoded from state and registered-state inputs only; `br_en` is stable in the BR state.
- Reset asserted mid-operation (for example during a LD1 wait) aborts immediately. `mem_read` drops in the same cycle, and no register enable is asserted.

## Test plan
1. **Reset and fetch.** Hold `rst` low for 3 cycles, release, feed `mem_resp` after 2 wait cycles. Expect:
   - outputs all 0 during reset;
   - then FETCH1 `load_mar`=1;
   - `mem_read`=1 for 3 cycles;
   - `load_ir` pulses exactly once.
2. **`add x3,x1,x2`, then `sub`** (funct7=0100000). Expect:
   - EXEC cycle: aluop=0 for add, then aluop=3 for sub;
   - alumux2=5, `load_regfile`=1, `load_pc`=1, pcmux=0.
3. **Branch.** Run beq twice, with `br_en`=1 then `br_en`=0. Expect pcmux=1, then pcmux=0, with cmpop=0 and alumux2=2 both times.
4. **Load.** Run lbu with a 1-cycle memory delay. Expect:
   - CALC_ADDR marmux=1, `load_mar`=1;
   - LD1 holds 2 cycles;
   - LD2 regfilemux=6 with `load_regfile`.
5. **Stores.** Run sb with `mem_addr_lo`=3 and sh with `mem_addr_lo`=2. Expect:
   - sb: `mem_byte_enable`=1000;
   - sh: `mem_byte_enable`=1100;
   - `load_data_out` asserted in CALC_ADDR;
   - `mem_write` held until `mem_resp`.
6. **JALR, illegal opcode, mid-load reset.** Expect:
   - JALR: pcmux=2, regfilemux=4;
   - opcode 1110011: ILLEGAL state, `load_pc` only;
   - `rst` low during an LD1 wait: `mem_read` drops immediately.
